// File: rtl/mmio_monitor_pkg.sv
// Shared types and address arithmetic for the MMIO monitor.
// The data and status addresses of each channel are computed here and nowhere else.
package mmio_monitor_pkg;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF8000;
    localparam int unsigned CH_STRIDE         = 8;
    localparam int unsigned DATA_OFFSET       = 4;

    // Computed at 64 bits; callers truncate to their own address width (ADDR_W <= 64).
    function automatic logic [63:0] status_addr(input logic [63:0] base, input logic [31:0] ch);
        return base + 64'(ch) * 64'(CH_STRIDE);
    endfunction

    function automatic logic [63:0] data_addr(input logic [63:0] base, input logic [31:0] ch);
        return status_addr(base, ch) + 64'(DATA_OFFSET);
    endfunction

endpackage

// File: rtl/mmio_monitor_if.sv
// Processor-side access, sticky-flag clears and monitor outputs as one bundle.
// inValid qualifies inAddress in the same cycle; there is no backpressure, every cycle is consumed.
interface mmio_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32
);
    logic              inValid;
    logic [ADDR_W-1:0] inAddress;
    logic [NUM_CH-1:0] statusClear;
    logic              overrunClear;
    logic [ADDR_W-1:0] outAddress;
    logic [NUM_CH-1:0] status;
    logic              busy;
    logic              overrun;

    modport master (
        output inValid, inAddress, statusClear, overrunClear,
        input  outAddress, status, busy, overrun
    );

    modport slave (
        input  inValid, inAddress, statusClear, overrunClear,
        output outAddress, status, busy, overrun
    );
endinterface

// File: rtl/mmio_addr_decode.sv
// Compares a qualified address against every channel's data address and
// reports a one-hot hit vector plus its encoded channel index.
module mmio_addr_decode
    import mmio_monitor_pkg::*;
#(
    parameter int                NUM_CH    = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int                IDX_W     = 2
) (
    input  logic              inValid,
    input  logic [ADDR_W-1:0] inAddress,
    output logic [NUM_CH-1:0] hit,
    output logic              hit_any,
    output logic [IDX_W-1:0]  hit_idx
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cmp
        assign hit[i] = inValid && (inAddress == ADDR_W'(data_addr(64'(BASE_ADDR), 32'(i))));
    end

    assign hit_any = |hit;

    // Data addresses are distinct, so at most one bit of hit is set.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hit[i]) hit_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/mmio_monitor.sv
// Watches processor accesses to per-channel data addresses and, on a hit,
// redirects the outgoing address to that channel's status word for HOLD_CYCLES cycles.
module mmio_monitor
    import mmio_monitor_pkg::*;
#(
    parameter int                NUM_CH      = 4,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int                HOLD_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    mmio_monitor_if.slave       bus,
    output state_t              dbg_state
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_CH-1:0] status_q;
    logic              overrun_q;
    logic              busy_q;

    logic [NUM_CH-1:0] hit;
    logic              hit_any;
    logic [IDX_W-1:0]  hit_idx;
    logic [ADDR_W-1:0] redirect_addr;

    mmio_addr_decode #(
        .NUM_CH    (NUM_CH),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_decode (
        .inValid   (bus.inValid),
        .inAddress (bus.inAddress),
        .hit       (hit),
        .hit_any   (hit_any),
        .hit_idx   (hit_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            status_q  <= '0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // A hit on the same edge as a clear keeps the flag set.
            status_q  <= (status_q & ~bus.statusClear) | hit;
            overrun_q <= (overrun_q & ~bus.overrunClear) | (hit_any && state_q == ST_REDIRECT);

            case (state_q)
                ST_IDLE: begin
                    if (hit_any) begin
                        state_q <= ST_REDIRECT;
                        busy_q  <= 1'b1;
                        idx_q   <= hit_idx;
                        cnt_q   <= CNT_W'(HOLD_CYCLES - 1);
                    end
                end
                ST_REDIRECT: begin
                    // Hits seen here only raise flags; the redirect is never extended.
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_addr  = ADDR_W'(status_addr(64'(BASE_ADDR), 32'(idx_q)));
    assign bus.outAddress = (state_q == ST_REDIRECT) ? redirect_addr : bus.inAddress;
    assign bus.status     = status_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = busy_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_mmio_monitor.sv
// Drives two monitors (hold 1 and hold 3) with identical traffic and checks both
// against a per-instance reference model through an expected-value queue.
module tb_mmio_monitor;
    import mmio_monitor_pkg::*;

    localparam int          NC   = 4;
    localparam int          AW   = 32;
    localparam logic [31:0] BASE = 32'hFFFF8000;
    localparam int          EW   = AW + NC + 3;
    localparam int          W    = 2 * EW;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    state_t st0, st1;

    mmio_monitor_if #(.NUM_CH(NC), .ADDR_W(AW)) bus0 ();
    mmio_monitor_if #(.NUM_CH(NC), .ADDR_W(AW)) bus1 ();

    mmio_monitor #(.NUM_CH(NC), .ADDR_W(AW), .BASE_ADDR(BASE), .HOLD_CYCLES(1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .dbg_state(st0)
    );
    mmio_monitor #(.NUM_CH(NC), .ADDR_W(AW), .BASE_ADDR(BASE), .HOLD_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .dbg_state(st1)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          hold_cfg [2] = '{1, 3};
    int          m_rem    [2];   // redirect cycles still to be shown
    int          m_ch     [2];
    logic [NC-1:0] m_status [2];
    logic        m_ovr    [2];

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic int model_hit(input logic v, input logic [31:0] a);
        longint off;
        off = longint'({32'd0, a}) - longint'({32'd0, BASE});
        if (!v) return -1;
        if (off >= 4 && ((off - 4) % 8) == 0 && ((off - 4) / 8) < NC) return int'((off - 4) / 8);
        return -1;
    endfunction

    function automatic logic [EW-1:0] model_out(input int k, input logic [31:0] a);
        logic [31:0] oa;
        oa = (m_rem[k] > 0) ? BASE + 32'(8 * m_ch[k]) : a;
        return {oa, m_status[k], m_rem[k] > 0, m_ovr[k], m_rem[k] > 0};
    endfunction

    task automatic model_step(input int k, input logic v, input logic [31:0] a,
                              input logic [NC-1:0] sc, input logic oc, input logic r);
        int h;
        h = model_hit(v, a);
        if (r) begin
            m_rem[k] = 0; m_ch[k] = 0; m_status[k] = '0; m_ovr[k] = 1'b0;
            return;
        end
        m_status[k] = m_status[k] & ~sc;
        if (oc) m_ovr[k] = 1'b0;
        if (h >= 0) begin
            m_status[k][h] = 1'b1;
            if (m_rem[k] > 0) m_ovr[k] = 1'b1;
        end
        if (m_rem[k] > 0) m_rem[k] = m_rem[k] - 1;
        else if (h >= 0) begin
            m_rem[k] = hold_cfg[k];
            m_ch[k]  = h;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [31:0] a, input logic [NC-1:0] sc,
                         input logic oc, input logic r);
        @(posedge clk);
        #1;
        reset = r;
        bus0.inValid = v; bus0.inAddress = a; bus0.statusClear = sc; bus0.overrunClear = oc;
        bus1.inValid = v; bus1.inAddress = a; bus1.statusClear = sc; bus1.overrunClear = oc;
        exp_q.push_back({model_out(1, a), model_out(0, a)});
        for (int k = 0; k < 2; k++) model_step(k, v, a, sc, oc, r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 4))
            0, 1:    return BASE + 32'd4 + 32'(8 * $urandom_range(0, NC - 1));
            2:       return BASE + 32'(8 * $urandom_range(0, NC - 1));
            3:       return BASE + 32'($urandom_range(0, 63));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_inst(input string tag, input logic [EW-1:0] e, input logic [EW-1:0] a);
        check({tag, ".outAddress"}, 64'(a[EW-1 -: AW]), 64'(e[EW-1 -: AW]));
        check({tag, ".status"},     64'(a[NC+2:3]),     64'(e[NC+2:3]));
        check({tag, ".busy"},       64'(a[2]),          64'(e[2]));
        check({tag, ".overrun"},    64'(a[1]),          64'(e[1]));
        check({tag, ".state"},      64'(a[0]),          64'(e[0]));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check_inst("hold1", e[EW-1:0],
                       {bus0.outAddress, bus0.status, bus0.busy, bus0.overrun, st0 == ST_REDIRECT});
            check_inst("hold3", e[W-1:EW],
                       {bus1.outAddress, bus1.status, bus1.busy, bus1.overrun, st1 == ST_REDIRECT});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < 2; k++) begin
            m_rem[k] = 0; m_ch[k] = 0; m_status[k] = '0; m_ovr[k] = 1'b0;
        end
        bus0.inValid = 1'b0; bus0.inAddress = '0; bus0.statusClear = '0; bus0.overrunClear = 1'b0;
        bus1.inValid = 1'b0; bus1.inAddress = '0; bus1.statusClear = '0; bus1.overrunClear = 1'b0;

        drive(1'b1, BASE + 32'h4, '0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, '0, 1'b0, 1'b1);
        idle(2);

        // single hit on channel 1, then passthrough
        drive(1'b1, 32'hFFFF800C, '0, 1'b0, 1'b0);
        idle(5);
        // channel 0 then channel 3 on the next cycle, then overrun clear
        drive(1'b1, 32'hFFFF8004, 4'b1111, 1'b0, 1'b0);
        drive(1'b1, 32'hFFFF801C, '0, 1'b0, 1'b0);
        idle(4);
        drive(1'b0, 32'h1234, '0, 1'b1, 1'b0);
        idle(1);
        // hit on channel 2 with a same-edge clear, then a lone clear
        drive(1'b1, 32'hFFFF8014, 4'b0100, 1'b0, 1'b0);
        idle(4);
        drive(1'b0, 32'h0, 4'b0100, 1'b0, 1'b0);
        idle(1);
        // suppressed and non-data window accesses
        drive(1'b0, 32'hFFFF8004, '0, 1'b0, 1'b0);
        drive(1'b1, 32'hFFFF8000, '0, 1'b0, 1'b0);
        drive(1'b1, 32'hFFFF8024, '0, 1'b0, 1'b0);
        // back-to-back hits with overrun, then reset mid-redirect
        drive(1'b1, 32'hFFFF8004, 4'b1111, 1'b1, 1'b0);
        drive(1'b1, 32'hFFFF800C, '0, 1'b0, 1'b0);
        drive(1'b1, 32'hFFFF800C, '0, 1'b0, 1'b0);
        drive(1'b1, 32'hFFFF8014, '0, 1'b0, 1'b1);
        drive(1'b0, 32'hDEADBEEF, '0, 1'b0, 1'b0);
        idle(2);

        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, pick_addr(),
                  ($urandom_range(0, 7) == 0) ? NC'($urandom) : '0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 99) == 0);
        end
        idle(3);

        repeat (4) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_monitor.md
MMIO_MONITOR -- requirements
Module: mmio_monitor

Interface
REQ-001 Parameter NUM_CH, default 4, number of monitored device channels (1..16).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter BASE_ADDR, default 32'hFFFF8000, base of the device window.
REQ-004 Parameter HOLD_CYCLES, default 1, cycles the status address is driven per accepted hit (1..15).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 inValid  input  1  access strobe; inAddress is only compared when high.
REQ-008 inAddress  input  ADDR_W  address from the processor datapath.
REQ-009 statusClear  input  NUM_CH  per-channel clear of sticky status bits.
REQ-010 overrunClear  input  1  clear of sticky overrun flag.
REQ-011 outAddress  output  ADDR_W  address forwarded to memory.
REQ-012 status  output  NUM_CH  registered sticky per-channel hit flags.
REQ-013 busy  output  1  high while in REDIRECT.
REQ-014 overrun  output  1  registered sticky flag: hit arrived while busy.

Function
REQ-015 Channel i data address SHALL be BASE_ADDR + 4 + 8*i; channel i status address SHALL be BASE_ADDR + 8*i.
REQ-016 Hit on channel i SHALL mean inValid high and inAddress equal to channel i data address; at most one channel can hit per cycle.
REQ-017 FSM states: IDLE, REDIRECT; a registered channel index and a hold counter of width sufficient for HOLD_CYCLES.
REQ-018 In IDLE, outAddress SHALL equal inAddress combinationally; busy low.
REQ-019 IDLE with a hit on channel i at edge k: state -> REDIRECT, index <- i, counter <- HOLD_CYCLES-1, status[i] <- 1.
REQ-020 In REDIRECT, outAddress SHALL equal the latched channel's status address, independent of inAddress; busy high.
REQ-021 REDIRECT with counter 0: state -> IDLE at next edge; otherwise counter decrements.
REQ-022 Redirect latency: status address appears in the cycle after the hit edge and lasts exactly HOLD_CYCLES cycles.
REQ-023 Hit while in REDIRECT (including its last cycle) SHALL set status[i] and overrun, SHALL NOT restart or extend the redirect, and SHALL NOT be queued.
REQ-024 A hit in the first IDLE cycle after REDIRECT SHALL be accepted normally (back-to-back hits allowed).
REQ-025 statusClear[i] SHALL clear status[i] at next edge; set on the same edge wins over clear.
REQ-026 overrunClear SHALL clear overrun at next edge; set on the same edge wins.
REQ-027 Addresses inside the window but not matching a data address (e.g. status addresses) SHALL pass through with no state change.
REQ-028 inValid low SHALL suppress all hit detection regardless of inAddress.

Reset
REQ-029 On reset high at an edge: state IDLE, counter 0, index 0, status all 0, overrun 0; reset overrides hits and clears in the same cycle.
REQ-030 Reset asserted mid-REDIRECT SHALL abort it; outAddress follows inAddress in the following cycle.

Structure
REQ-031 Package mmio_monitor_pkg SHALL hold the state enum, default BASE_ADDR, channel stride (8), data offset (4), and address-computation functions.
REQ-032 Sub-module mmio_addr_decode SHALL produce the one-hot hit vector and encoded index from inAddress, inValid; all other logic stays in mmio_monitor.
REQ-033 No latches; outAddress is the only combinational output.

Verification (NUM_CH=4, HOLD_CYCLES=1, BASE 32'hFFFF8000)
REQ-034 inValid=1, inAddress=FFFF800C for one cycle -> next cycle outAddress=FFFF8008, busy=1, status=4'b0010; following cycle passthrough.
REQ-035 HOLD_CYCLES=3, hit FFFF8004 -> outAddress=FFFF8000 for exactly 3 cycles, busy 3 cycles.
REQ-036 Hit FFFF8004 then hit FFFF801C the next cycle -> no second redirect, status=4'b1001, overrun=1; overrunClear pulse -> overrun=0.
REQ-037 Hit FFFF8014 in the same cycle as statusClear=4'b0100 -> status[2]=1; later statusClear=4'b0100 alone -> status[2]=0.
REQ-038 inValid=0 with inAddress=FFFF8004, and inValid=1 with FFFF8000 -> passthrough, busy=0, status unchanged.
REQ-039 Reset pulsed during REDIRECT with status=4'b0011, overrun=1 -> next cycle busy=0, status=0, overrun=0, outAddress=inAddress.
